writeback_arbiter: RTL and testbench

- Shares a single writeback/complete port among p_num_pipes execution units (ALU, multiplier, load/store).
- Sits between the execute units' X→W outputs and the writeback/commit stage.
- Each cycle, grants at most one valid requester into a one-entry registered output slot. Arbitration is round-robin by default.
- Oldest-first arbitration (by sequence number) is available via a compile-time feature.

---
 rtl/writeback_arbiter_if.sv | 56 +++++
 rtl/writeback_arbiter.sv | 159 +++++++++++++++
 tb/tb_writeback_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter_if
// Description : Bundle of signals between the execute pipes, the writeback
//               arbiter and the writeback/commit stage.
//               Request side (flattened, pipe i at [i*W +: W]):
//                 req_val, req_rdy, req_seq_num, req_waddr, req_wdata,
//                 req_wen, req_pc, head_seq_num
//               Output slot side:
//                 out_val, out_rdy, out_seq_num, out_waddr, out_wdata,
//                 out_wen, out_pc, out_src
//               Modports:
//                 slave  - the arbiter (consumes requests, drives out_*)
//                 master - the environment (drives requests, takes out_*)
// Revision    : 1.0 - initial release
// ============================================================================
interface writeback_arbiter_if #(
  parameter int p_num_pipes      = 3,
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6
);
  localparam int SRC_W = $clog2(p_num_pipes);

  logic [p_num_pipes-1:0]                  req_val;
  logic [p_num_pipes-1:0]                  req_rdy;
  logic [p_num_pipes*p_seq_num_bits-1:0]   req_seq_num;
  logic [p_num_pipes*p_phys_addr_bits-1:0] req_waddr;
  logic [p_num_pipes*32-1:0]               req_wdata;
  logic [p_num_pipes-1:0]                  req_wen;
  logic [p_num_pipes*32-1:0]               req_pc;
  logic [p_seq_num_bits-1:0]               head_seq_num;

  logic                                    out_val;
  logic                                    out_rdy;
  logic [p_seq_num_bits-1:0]               out_seq_num;
  logic [p_phys_addr_bits-1:0]             out_waddr;
  logic [31:0]                             out_wdata;
  logic                                    out_wen;
  logic [31:0]                             out_pc;
  logic [SRC_W-1:0]                        out_src;

  modport slave (
    input  req_val, req_seq_num, req_waddr, req_wdata, req_wen, req_pc,
           head_seq_num, out_rdy,
    output req_rdy, out_val, out_seq_num, out_waddr, out_wdata, out_wen,
           out_pc, out_src
  );

  modport master (
    output req_val, req_seq_num, req_waddr, req_wdata, req_wen, req_pc,
           head_seq_num, out_rdy,
    input  req_rdy, out_val, out_seq_num, out_waddr, out_wdata, out_wen,
           out_pc, out_src
  );
endinterface
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Shares one writeback/complete port among p_num_pipes execute
//               pipes. Each cycle at most one valid requester is granted into
//               a one-entry registered output slot. Round-robin by default;
//               oldest-first (by sequence number relative to head_seq_num)
//               when the macro WRITEBACK_ARB_OLDEST_FIRST_EN is defined.
// Ports       : clk - clock
//               rst - asynchronous reset, active low
//               bus - writeback_arbiter_if.slave (requests in, slot out)
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter #(
  parameter int p_num_pipes      = 3,
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  writeback_arbiter_if.slave   bus
);
  localparam int                SRC_W = $clog2(p_num_pipes);
  localparam int                S     = p_seq_num_bits;
  localparam int                A     = p_phys_addr_bits;
  localparam logic [SRC_W-1:0]  LAST  = SRC_W'(p_num_pipes - 1);

  // Per-pipe views of the flattened request fields
  logic [S-1:0]  seq_arr   [p_num_pipes];
  logic [A-1:0]  waddr_arr [p_num_pipes];
  logic [31:0]   wdata_arr [p_num_pipes];
  logic [31:0]   pc_arr    [p_num_pipes];

  genvar gi;
  generate
    for (gi = 0; gi < p_num_pipes; gi++) begin : g_pipe
      assign seq_arr[gi]   = bus.req_seq_num[gi*S +: S];
      assign waddr_arr[gi] = bus.req_waddr[gi*A +: A];
      assign wdata_arr[gi] = bus.req_wdata[gi*32 +: 32];
      assign pc_arr[gi]    = bus.req_pc[gi*32 +: 32];
    end
  endgenerate

  logic [SRC_W-1:0]        ptr;
  logic [SRC_W-1:0]        gnt_idx;
  logic                    any_val;
  logic                    can_load;
  logic                    grant;
  logic [p_num_pipes-1:0]  rdy_vec;

  logic                    out_val_q;
  logic [S-1:0]            out_seq_q;
  logic [A-1:0]            out_waddr_q;
  logic [31:0]             out_wdata_q;
  logic                    out_wen_q;
  logic [31:0]             out_pc_q;
  logic [SRC_W-1:0]        out_src_q;

  assign any_val  = |bus.req_val;
  assign can_load = !out_val_q | bus.out_rdy;
  // rst gates the grant so req_rdy stays low throughout reset even though
  // the slot reads as empty.
  assign grant    = can_load & any_val & rst;

`ifdef WRITEBACK_ARB_OLDEST_FIRST_EN
  // Oldest-first: smallest modular distance from the head of the window.
  // Strict '<' keeps the lowest index on ties.
  logic [S-1:0] age;
  logic [S-1:0] best_age;
  logic         of_found;

  always_comb begin
    gnt_idx  = '0;
    best_age = '1;
    of_found = 1'b0;
    age      = '0;
    for (int i = 0; i < p_num_pipes; i++) begin
      age = seq_arr[i] - bus.head_seq_num;
      if (bus.req_val[i] && (!of_found || age < best_age)) begin
        of_found = 1'b1;
        best_age = age;
        gnt_idx  = SRC_W'(i);
      end
    end
  end

  // The pointer keeps rotating so behaviour is identical if the feature is
  // later switched off, but selection does not consult it.
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`else
  // Round-robin: scan upward from ptr with wrap; first valid index wins.
  logic rr_found;
  int   rr_idx;

  always_comb begin
    gnt_idx  = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int k = 0; k < p_num_pipes; k++) begin
      rr_idx = int'(ptr) + k;
      if (rr_idx >= p_num_pipes) begin
        rr_idx = rr_idx - p_num_pipes;
      end
      if (!rr_found && bus.req_val[rr_idx]) begin
        rr_found = 1'b1;
        gnt_idx  = SRC_W'(rr_idx);
      end
    end
  end

  logic unused_head;
  assign unused_head = ^bus.head_seq_num;
`endif

  always_comb begin
    rdy_vec = '0;
    if (grant) begin
      rdy_vec[gnt_idx] = 1'b1;
    end
  end

  // Output slot and priority pointer. A grant while the slot drains
  // replaces the entry in the same edge, so there is no bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_val_q   <= 1'b0;
      out_seq_q   <= '0;
      out_waddr_q <= '0;
      out_wdata_q <= '0;
      out_wen_q   <= 1'b0;
      out_pc_q    <= '0;
      out_src_q   <= '0;
      ptr         <= '0;
    end else if (grant) begin
      out_val_q   <= 1'b1;
      out_seq_q   <= seq_arr[gnt_idx];
      out_waddr_q <= waddr_arr[gnt_idx];
      out_wdata_q <= wdata_arr[gnt_idx];
      out_wen_q   <= bus.req_wen[gnt_idx];
      out_pc_q    <= pc_arr[gnt_idx];
      out_src_q   <= gnt_idx;
      ptr         <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
    end else if (out_val_q && bus.out_rdy) begin
      out_val_q   <= 1'b0;
    end
  end

  assign bus.req_rdy     = rdy_vec;
  assign bus.out_val     = out_val_q;
  assign bus.out_seq_num = out_seq_q;
  assign bus.out_waddr   = out_waddr_q;
  assign bus.out_wdata   = out_wdata_q;
  assign bus.out_wen     = out_wen_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_src     = out_src_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_arbiter
// Description : Self-checking bench for writeback_arbiter. Expected output
//               entries are queued when a grant is expected and compared when
//               the slot presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;
  localparam int N = 3;
  localparam int S = 5;
  localparam int A = 6;

  typedef struct packed {
    logic [1:0]   src;
    logic [S-1:0] seq;
    logic [A-1:0] waddr;
    logic [31:0]  wdata;
    logic         wen;
    logic [31:0]  pc;
  } ent_t;

  logic clk;
  logic rst;

  writeback_arbiter_if #(.p_num_pipes(N), .p_seq_num_bits(S), .p_phys_addr_bits(A)) bus ();

  writeback_arbiter #(.p_num_pipes(N), .p_seq_num_bits(S), .p_phys_addr_bits(A)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  ent_t exp_q[$];
  ent_t e;
  ent_t got;

  logic [S-1:0] p_seq   [N];
  logic [A-1:0] p_waddr [N];
  logic [31:0]  p_wdata [N];
  logic         p_wen   [N];
  logic [31:0]  p_pc    [N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input int i, input logic [S-1:0] seq, input logic [A-1:0] waddr,
                          input logic [31:0] wdata, input logic wen, input logic [31:0] pc);
    p_seq[i] = seq; p_waddr[i] = waddr; p_wdata[i] = wdata; p_wen[i] = wen; p_pc[i] = pc;
    bus.req_seq_num[i*S +: S] = seq;
    bus.req_waddr[i*A +: A]   = waddr;
    bus.req_wdata[i*32 +: 32] = wdata;
    bus.req_wen[i]            = wen;
    bus.req_pc[i*32 +: 32]    = pc;
  endtask

  function automatic ent_t pipe_ent(input int i);
    ent_t r;
    r.src = 2'(i); r.seq = p_seq[i]; r.waddr = p_waddr[i];
    r.wdata = p_wdata[i]; r.wen = p_wen[i]; r.pc = p_pc[i];
    return r;
  endfunction

  function automatic ent_t dut_out();
    ent_t r;
    r.src = bus.out_src; r.seq = bus.out_seq_num; r.waddr = bus.out_waddr;
    r.wdata = bus.out_wdata; r.wen = bus.out_wen; r.pc = bus.out_pc;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    bus.req_val = '0;
    tick();
    rst = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req_val = '0;
    bus.out_rdy = 1'b0;
    bus.head_seq_num = '0;
    for (int i = 0; i < N; i++) set_pipe(i, '0, '0, '0, 1'b0, '0);
    #3;
    vectors++;
    if (bus.out_val !== 1'b0 || bus.req_rdy !== 3'b000 || dut_out() !== '0) begin
      miscompares++;
      $display("FAIL reset_in: val=%b rdy=%b out=%h required val=0 rdy=000 out=0",
               bus.out_val, bus.req_rdy, dut_out());
    end
    tick();
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if (bus.out_val !== 1'b0 || bus.req_rdy !== 3'b000 || bus.out_src !== 2'd0) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: val=%b rdy=%b src=%0d required 0/000/0",
                 c, bus.out_val, bus.req_rdy, bus.out_src);
      end
    end
  endtask

  task automatic test_single();
    set_pipe(1, 5'd3, 6'd10, 32'hDEADBEEF, 1'b1, 32'h0000_0100);
    bus.req_val = 3'b010;
    bus.out_rdy = 1'b1;
    #1;
    vectors++;
    if (bus.req_rdy !== 3'b010) begin
      miscompares++;
      $display("FAIL single_rdy: got %b required 010", bus.req_rdy);
    end
    exp_q.push_back(pipe_ent(1));
    tick();
    bus.req_val = 3'b000;
    vectors++;
    if (bus.out_val !== 1'b1 || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL single_val: out_val=%b required 1", bus.out_val);
    end else begin
      e = exp_q.pop_front();
      got = dut_out();
      if (got !== e) begin
        miscompares++;
        $display("FAIL single_entry: got %h required %h", got, e);
      end
    end
    tick();
    vectors++;
    if (bus.out_val !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drain: out_val=%b required 0", bus.out_val);
    end
  endtask

  task automatic test_round_robin();
    int exp_src [6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    for (int k = 0; k < N; k++)
      set_pipe(k, 5'(k + 8), 6'(k + 20), 32'hA000_0000 + 32'(k), (k != 1), 32'h1000 + 32'(4 * k));
    bus.out_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.req_val = 3'b111;
      #1;
      vectors++;
      if (bus.req_rdy !== (3'b001 << exp_src[c])) begin
        miscompares++;
        $display("FAIL rr_rdy[%0d]: got %b required %b", c, bus.req_rdy, 3'b001 << exp_src[c]);
      end
      exp_q.push_back(pipe_ent(exp_src[c]));
      tick();
      vectors++;
      if (bus.out_val !== 1'b1 || exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rr_bubble[%0d]: out_val=%b required 1", c, bus.out_val);
      end else begin
        e = exp_q.pop_front();
        got = dut_out();
        if (got !== e) begin
          miscompares++;
          $display("FAIL rr_entry[%0d]: got %h required %h", c, got, e);
        end
      end
    end
    bus.req_val = 3'b000;
    tick();
    vectors++;
    if (bus.out_val !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_drain: out_val=%b required 0", bus.out_val);
    end
  endtask

  task automatic test_backpressure();
    // Pointer is 0 after the round-robin run ended on pipe 2.
    set_pipe(0, 5'd1, 6'd5, 32'h0000_0011, 1'b1, 32'h2000);
    bus.req_val = 3'b001;
    bus.out_rdy = 1'b1;
    #1;
    vectors++;
    if (bus.req_rdy !== 3'b001) begin
      miscompares++;
      $display("FAIL bp_first_rdy: got %b required 001", bus.req_rdy);
    end
    exp_q.push_back(pipe_ent(0));
    tick();
    bus.out_rdy = 1'b0;
    bus.req_val = 3'b110;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (bus.req_rdy !== 3'b000 || bus.out_val !== 1'b1 || exp_q.size() == 0 || dut_out() !== exp_q[0]) begin
        miscompares++;
        $display("FAIL bp_stall[%0d]: rdy=%b val=%b out=%h required rdy=000 val=1 held entry",
                 c, bus.req_rdy, bus.out_val, dut_out());
      end
      tick();
    end
    bus.out_rdy = 1'b1;
    #1;
    vectors++;
    if (bus.req_rdy !== 3'b010) begin
      miscompares++;
      $display("FAIL bp_release_rdy: got %b required 010", bus.req_rdy);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    exp_q.push_back(pipe_ent(1));
    tick();
    bus.req_val = 3'b000;
    vectors++;
    if (bus.out_val !== 1'b1 || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL bp_after_val: out_val=%b required 1", bus.out_val);
    end else begin
      e = exp_q.pop_front();
      got = dut_out();
      if (got !== e) begin
        miscompares++;
        $display("FAIL bp_after_entry: got %h required %h", got, e);
      end
    end
    tick();
  endtask

  task automatic test_async_reset();
    // Pointer is 2; pipe 0 is the only requester so it wins after wrap.
    set_pipe(0, 5'd4, 6'd33, 32'hCAFE_F00D, 1'b0, 32'h3000);
    bus.req_val = 3'b001;
    bus.out_rdy = 1'b1;
    #1;
    exp_q.push_back(pipe_ent(0));
    tick();
    bus.req_val = 3'b000;
    bus.out_rdy = 1'b0;
    #1;
    vectors++;
    if (bus.out_val !== 1'b1 || exp_q.size() == 0 || dut_out() !== exp_q[0]) begin
      miscompares++;
      $display("FAIL ar_setup: val=%b out=%h required val=1 pipe0 entry", bus.out_val, dut_out());
    end
    #2;
    rst = 1'b0;
    bus.req_val = 3'b111;
    bus.out_rdy = 1'b1;
    #1;
    vectors++;
    if (bus.out_val !== 1'b0 || dut_out() !== '0 || bus.req_rdy !== 3'b000) begin
      miscompares++;
      $display("FAIL ar_async: val=%b out=%h rdy=%b required 0/0/000",
               bus.out_val, dut_out(), bus.req_rdy);
    end
    exp_q.delete();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.req_rdy !== 3'b001) begin
      miscompares++;
      $display("FAIL ar_ptr: rdy=%b required 001", bus.req_rdy);
    end
    exp_q.push_back(pipe_ent(0));
    tick();
    bus.req_val = 3'b000;
    vectors++;
    if (bus.out_val !== 1'b1 || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL ar_post_val: out_val=%b required 1", bus.out_val);
    end else begin
      e = exp_q.pop_front();
      got = dut_out();
      if (got !== e) begin
        miscompares++;
        $display("FAIL ar_post_entry: got %h required %h", got, e);
      end
    end
    tick();
  endtask

`ifdef WRITEBACK_ARB_OLDEST_FIRST_EN
  task automatic test_oldest_first();
    logic [2:0] vals [3] = '{3'b111, 3'b101, 3'b001};
    int         gsrc [3] = '{1, 2, 0};
    do_reset();
    bus.head_seq_num = 5'd30;
    set_pipe(0, 5'd2,  6'd1, 32'h0000_0A00, 1'b1, 32'h4000);
    set_pipe(1, 5'd31, 6'd2, 32'h0000_0A01, 1'b1, 32'h4004);
    set_pipe(2, 5'd0,  6'd3, 32'h0000_0A02, 1'b1, 32'h4008);
    bus.out_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.req_val = vals[c];
      #1;
      vectors++;
      if (bus.req_rdy !== (3'b001 << gsrc[c])) begin
        miscompares++;
        $display("FAIL of_rdy[%0d]: got %b required %b", c, bus.req_rdy, 3'b001 << gsrc[c]);
      end
      exp_q.push_back(pipe_ent(gsrc[c]));
      tick();
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL of_queue[%0d]: no expected entry", c);
      end else begin
        e = exp_q.pop_front();
        got = dut_out();
        if (got !== e || bus.out_val !== 1'b1) begin
          miscompares++;
          $display("FAIL of_entry[%0d]: got %h val=%b required %h val=1", c, got, bus.out_val, e);
        end
      end
    end
    bus.req_val = 3'b000;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_async_reset();
`ifdef WRITEBACK_ARB_OLDEST_FIRST_EN
    test_oldest_first();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
